// File: rtl/fetch_predict_unit.sv
// Fetch front-end: PC register, direct-mapped BTB with 2-bit counters,
// next-PC prediction, MEM-stage resolution with flush, and saturating stats.
module fetch_predict_unit #(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    BTB_ENTRIES = 8,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
   parameter int                    COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   stall,
   output logic [ADDR_WIDTH-1:0]  inst_address,
   output logic                   pred_taken_IF,
   output logic [ADDR_WIDTH-1:0]  pred_target_IF,
   input  logic                   resolve_valid,
   input  logic                   resolve_is_branch,
   input  logic                   resolve_is_jump,
   input  logic [ADDR_WIDTH-1:0]  resolve_addr,
   input  logic                   resolve_taken,
   input  logic [ADDR_WIDTH-1:0]  resolve_target,
   input  logic                   resolve_pred_taken,
   input  logic [ADDR_WIDTH-1:0]  resolve_pred_target,
   output logic                   flush,
   output logic [COUNT_WIDTH-1:0] branch_count,
   output logic [COUNT_WIDTH-1:0] mispredict_count
);

   localparam int IDX_W = $clog2(BTB_ENTRIES);
   localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;

   logic [ADDR_WIDTH-1:0]  pc;
   logic [BTB_ENTRIES-1:0] btb_valid;
   logic [1:0]             btb_ctr    [BTB_ENTRIES];
   logic [TAG_W-1:0]       btb_tag    [BTB_ENTRIES];
   logic [ADDR_WIDTH-1:0]  btb_target [BTB_ENTRIES];

   logic [IDX_W-1:0]       l_idx, r_idx;
   logic [TAG_W-1:0]       l_tag, r_tag;
   logic                   l_hit, r_hit;
   logic [ADDR_WIDTH-1:0]  pc_plus4, corrected_pc, target_aligned;
   logic                   mispredict;

   assign l_idx = pc[IDX_W+1:2];
   assign l_tag = pc[ADDR_WIDTH-1:IDX_W+2];
   assign l_hit = btb_valid[l_idx] && (btb_tag[l_idx] == l_tag);

   assign pc_plus4       = pc + ADDR_WIDTH'(4);
   assign inst_address   = pc;
   assign pred_taken_IF  = l_hit && btb_ctr[l_idx][1];
   assign pred_target_IF = pred_taken_IF ? btb_target[l_idx] : pc_plus4;

   assign r_idx = resolve_addr[IDX_W+1:2];
   assign r_tag = resolve_addr[ADDR_WIDTH-1:IDX_W+2];
   assign r_hit = btb_valid[r_idx] && (btb_tag[r_idx] == r_tag);

   // A non-branch carrying a taken prediction means the BTB aliased onto it.
   always_comb begin
      mispredict = 1'b0;
      if (resolve_valid) begin
         if (resolve_is_branch)
            mispredict = (resolve_taken != resolve_pred_taken) ||
                         (resolve_taken && resolve_pred_taken &&
                          (resolve_target != resolve_pred_target));
         else
            mispredict = resolve_pred_taken;
      end
   end

   assign flush          = mispredict;
   assign corrected_pc   = (resolve_is_branch && resolve_taken) ? resolve_target
                                                                : resolve_addr + ADDR_WIDTH'(4);
   assign target_aligned = {resolve_target[ADDR_WIDTH-1:2], 2'b00};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= RESET_PC;
      end else if (mispredict) begin
         pc <= corrected_pc;
      end else if (!stall) begin
         pc <= pred_target_IF;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btb_valid <= '0;
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            btb_ctr[i]    <= '0;
            btb_tag[i]    <= '0;
            btb_target[i] <= '0;
         end
      end else if (resolve_valid) begin
         if (resolve_is_branch) begin
            if (r_hit) begin
               if (resolve_taken) begin
                  btb_target[r_idx] <= target_aligned;
                  if (resolve_is_jump || btb_ctr[r_idx] == 2'd3)
                     btb_ctr[r_idx] <= 2'd3;
                  else
                     btb_ctr[r_idx] <= btb_ctr[r_idx] + 2'd1;
               end else if (resolve_is_jump) begin
                  btb_ctr[r_idx] <= 2'd3;
               end else if (btb_ctr[r_idx] != 2'd0) begin
                  btb_ctr[r_idx] <= btb_ctr[r_idx] - 2'd1;
               end
            end else if (resolve_taken) begin
               btb_valid[r_idx]  <= 1'b1;
               btb_tag[r_idx]    <= r_tag;
               btb_target[r_idx] <= target_aligned;
               btb_ctr[r_idx]    <= resolve_is_jump ? 2'd3 : 2'd2;
            end
         end else if (r_hit) begin
            btb_valid[r_idx] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         branch_count     <= '0;
         mispredict_count <= '0;
      end else begin
         if (resolve_valid && resolve_is_branch && !(&branch_count))
            branch_count <= branch_count + COUNT_WIDTH'(1);
         if (mispredict && !(&mispredict_count))
            mispredict_count <= mispredict_count + COUNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_fetch_predict_unit.sv
// Directed bench for fetch_predict_unit; expected outputs queue up as stimulus
// is driven and are drained against the DUT once the outputs settle.
module tb_fetch_predict_unit;

   localparam int AW   = 32;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          stall = 1'b0;
   logic [AW-1:0] inst_address;
   logic          pred_taken_IF;
   logic [AW-1:0] pred_target_IF;
   logic          resolve_valid = 1'b0;
   logic          resolve_is_branch = 1'b0;
   logic          resolve_is_jump = 1'b0;
   logic [AW-1:0] resolve_addr = '0;
   logic          resolve_taken = 1'b0;
   logic [AW-1:0] resolve_target = '0;
   logic          resolve_pred_taken = 1'b0;
   logic [AW-1:0] resolve_pred_target = '0;
   logic          flush;
   logic [CW-1:0] branch_count;
   logic [CW-1:0] mispredict_count;

   always #5 clk = ~clk;

   fetch_predict_unit #(
      .ADDR_WIDTH(AW), .BTB_ENTRIES(8), .RESET_PC('0), .COUNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall),
      .inst_address(inst_address), .pred_taken_IF(pred_taken_IF),
      .pred_target_IF(pred_target_IF),
      .resolve_valid(resolve_valid), .resolve_is_branch(resolve_is_branch),
      .resolve_is_jump(resolve_is_jump), .resolve_addr(resolve_addr),
      .resolve_taken(resolve_taken), .resolve_target(resolve_target),
      .resolve_pred_taken(resolve_pred_taken),
      .resolve_pred_target(resolve_pred_target),
      .flush(flush), .branch_count(branch_count),
      .mispredict_count(mispredict_count)
   );

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] val;
   } exp_t;

   localparam int S_PC = 0, S_PT = 1, S_PTG = 2, S_FL = 3, S_BC = 4, S_MC = 5;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   bc_m = 0;
   int   mc_m = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] observe(input int sel);
      case (sel)
         S_PC:    return inst_address;
         S_PT:    return {31'b0, pred_taken_IF};
         S_PTG:   return pred_target_IF;
         S_FL:    return {31'b0, flush};
         S_BC:    return 32'(branch_count);
         default: return 32'(mispredict_count);
      endcase
   endfunction

   task automatic expect_val(input string tag, input int sel, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.val = v;
      q.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      while (q.size() > 0) begin
         e = q.pop_front();
         chk(e.tag, observe(e.sel), e.val);
      end
   endtask

   function automatic int sat(input int x);
      return (x < CMAX) ? x + 1 : CMAX;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One resolve cycle: flush is checked combinationally, counters after the edge.
   task automatic res(input string tag, input logic br, input logic j,
                      input logic [31:0] a, input logic t, input logic [31:0] tg,
                      input logic pt, input logic [31:0] ptg, input logic ef);
      resolve_valid       = 1'b1;
      resolve_is_branch   = br;
      resolve_is_jump     = j;
      resolve_addr        = a;
      resolve_taken       = t;
      resolve_target      = tg;
      resolve_pred_taken  = pt;
      resolve_pred_target = ptg;
      #1;
      expect_val({tag, "_flush"}, S_FL, {31'b0, ef});
      drain();
      if (br) bc_m = sat(bc_m);
      if (ef) mc_m = sat(mc_m);
      tick();
      resolve_valid = 1'b0;
      #1;
      expect_val({tag, "_bc"}, S_BC, 32'(bc_m));
      expect_val({tag, "_mc"}, S_MC, 32'(mc_m));
      drain();
   endtask

   task automatic pc_is(input string tag, input logic [31:0] v);
      expect_val(tag, S_PC, v);
      drain();
   endtask

   // Steer the PC with a non-branch falsely predicted taken at target-4.
   task automatic redirect(input logic [31:0] target);
      res("redir", 1'b0, 1'b0, target - 32'd4, 1'b0, 32'd0, 1'b1, target, 1'b1);
      pc_is("redir_pc", target);
   endtask

   task automatic pred_is(input string tag, input logic pt, input logic [31:0] ptg);
      expect_val({tag, "_pt"}, S_PT, {31'b0, pt});
      expect_val({tag, "_ptg"}, S_PTG, ptg);
      drain();
   endtask

   initial begin
      #12 rst_n = 1'b1;
      #1;
      // 1: reset state and free run
      pc_is("rst_pc", 32'h0);
      pred_is("rst", 1'b0, 32'h4);
      expect_val("rst_flush", S_FL, 32'd0);
      expect_val("rst_bc", S_BC, 32'd0);
      expect_val("rst_mc", S_MC, 32'd0);
      drain();
      tick(); pc_is("run_pc1", 32'h4);
      tick(); pc_is("run_pc2", 32'h8);
      tick(); pc_is("run_pc3", 32'hC);
      pred_is("run", 1'b0, 32'h10);

      // 2: BEQ miss, taken -> allocate with counter 2
      res("beq_alloc", 1'b1, 1'b0, 32'h10, 1'b1, 32'h40, 1'b0, 32'h14, 1'b1);
      pc_is("beq_alloc_pc", 32'h40);
      redirect(32'h10);
      pred_is("beq_hit", 1'b1, 32'h40);
      tick(); pc_is("beq_follow_pc", 32'h40);

      // 3: two not-taken resolves walk the counter 2->1->0
      res("nt1", 1'b1, 1'b0, 32'h10, 1'b0, 32'h40, 1'b1, 32'h40, 1'b1);
      pc_is("nt1_pc", 32'h14);
      res("nt2", 1'b1, 1'b0, 32'h10, 1'b0, 32'h40, 1'b1, 32'h40, 1'b1);
      pc_is("nt2_pc", 32'h14);
      redirect(32'h10);
      pred_is("nt_weak", 1'b0, 32'h14);

      // 4: J miss allocates with counter 3; correct resolves do not flush
      res("j_alloc", 1'b1, 1'b1, 32'h20, 1'b1, 32'h100, 1'b0, 32'h24, 1'b1);
      pc_is("j_alloc_pc", 32'h100);
      for (int k = 0; k < 3; k++) begin
         res("j_ok", 1'b1, 1'b1, 32'h20, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0);
         pc_is("j_ok_pc", 32'h104 + 32'(4 * k));
      end
      redirect(32'h20);
      pred_is("j_hit", 1'b1, 32'h100);

      // 5: mispredict overrides stall; plain stall holds
      stall = 1'b1;
      res("stall_mp", 1'b1, 1'b0, 32'h10, 1'b1, 32'h40, 1'b0, 32'h14, 1'b1);
      pc_is("stall_mp_pc", 32'h40);
      for (int k = 0; k < 3; k++) begin
         tick(); pc_is("stall_hold_pc", 32'h40);
      end
      stall = 1'b0;

      // 6: non-branch aliasing a taken entry invalidates it
      res("alias_alloc", 1'b1, 1'b0, 32'h30, 1'b1, 32'h80, 1'b0, 32'h34, 1'b1);
      pc_is("alias_alloc_pc", 32'h80);
      res("alias_nb", 1'b0, 1'b0, 32'h30, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1);
      pc_is("alias_nb_pc", 32'h34);
      redirect(32'h30);
      pred_is("alias_inval", 1'b0, 32'h34);

      // statistics saturate at all-ones
      for (int k = 0; k < 8; k++) begin
         res("sat", 1'b1, 1'b0, 32'hC, 1'b0, 32'h0, 1'b1, 32'h10, 1'b1);
         pc_is("sat_pc", 32'h10);
      end
      expect_val("sat_bc_max", S_BC, 32'(CMAX));
      expect_val("sat_mc_max", S_MC, 32'(CMAX));
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_predict_unit.md
Name: fetch_predict_unit

Overview:
- Parametrised fetch front-end that replaces the fixed PC-plus-branch logic of the pipeline.
- Holds the PC and a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, and predicts next-PC every cycle.
- Accepts branch/jump resolution from the MEM stage and raises a flush with a corrected PC on misprediction.
- Keeps saturating branch and mispredict statistics counters.

Parameters:
ADDR_WIDTH, 32, width of PC and all address/target ports
BTB_ENTRIES, 8, number of BTB entries; power of two, minimum 2
RESET_PC, 0, PC value loaded on reset
COUNT_WIDTH, 16, width of the statistics counters

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
stall  input  1  load-use stall from ID; hold PC
inst_address  output  ADDR_WIDTH  current fetch PC to instruction memory
pred_taken_IF  output  1  prediction for the instruction at inst_address; carried down the pipeline
pred_target_IF  output  ADDR_WIDTH  predicted target; equals inst_address+4 when not predicted taken
resolve_valid  input  1  an instruction is resolving in MEM this cycle
resolve_is_branch  input  1  resolving instruction is BEQ or J
resolve_is_jump  input  1  resolving instruction is J; only meaningful with resolve_is_branch
resolve_addr  input  ADDR_WIDTH  PC of the resolving instruction
resolve_taken  input  1  actual outcome; must be 1 for J
resolve_target  input  ADDR_WIDTH  actual taken target
resolve_pred_taken  input  1  pred_taken_IF carried with that instruction
resolve_pred_target  input  ADDR_WIDTH  pred_target_IF carried with that instruction
flush  output  1  mispredict; squash IF/ID, ID/EX and EX/MEM
branch_count  output  COUNT_WIDTH  resolved BEQ/J count
mispredict_count  output  COUNT_WIDTH  mispredict count

Behaviour:
- Reset is asynchronous: PC=RESET_PC; all BTB valid bits, counters, tags and targets=0; branch_count=0; mispredict_count=0.
- Addressing:
  - PC bits [1:0] are ignored.
  - index = PC[log2(BTB_ENTRIES)+1:2]; tag = PC[ADDR_WIDTH-1:log2(BTB_ENTRIES)+2].
  - Stored targets have bits [1:0] forced to 0.
- Lookup is combinational on the current PC against the registered BTB.
  - hit = valid and tag match.
  - pred_taken_IF = hit and counter[1].
  - pred_target_IF = stored target when pred_taken_IF is 1, else PC+4.
- Mispredict is combinational and requires resolve_valid=1. It is asserted when any of these hold:
  - branch: resolve_taken differs from resolve_pred_taken;
  - branch: both taken but resolve_target differs from resolve_pred_target;
  - non-branch with resolve_pred_taken=1 (aliased false hit).
  - flush = mispredict in the same cycle.
- Corrected PC = resolve_target if (branch and resolve_taken), else resolve_addr+4.
- Next-PC priority at each rising edge:
  1. mispredict: corrected PC. This overrides stall.
  2. stall: hold.
  3. pred_taken_IF: pred_target_IF.
  4. otherwise PC+4.
- Addition wraps modulo 2^ADDR_WIDTH.
- BTB update is registered at the edge, indexed by resolve_addr, and happens only when resolve_valid=1.
  - Branch, hit, taken: counter saturating-increment (max 3); target updated.
  - Branch, hit, not taken: counter saturating-decrement (min 0); entry stays valid.
  - Branch, miss, taken: allocate and overwrite the slot. Set tag and target. Counter = 3 for J, 2 for BEQ.
  - Branch, miss, not taken: no allocation.
  - J always forces counter to 3.
  - Non-branch with a hit: clear that entry's valid bit.
- Lookup and update on the same index in the same cycle: lookup sees pre-update contents.
- Statistics:
  - branch_count increments on resolve_valid and resolve_is_branch.
  - mispredict_count increments on mispredict.
  - Both saturate at all-ones and never wrap.
- resolve_* inputs are ignored when resolve_valid=0.
- Reset asserted mid-operation discards pending updates immediately.

Test Plan:
1. Reset, then 4 free-running cycles -> inst_address 0x0, 0x4, 0x8, 0xC; pred_taken_IF=0; flush=0; counters 0.
2. Resolve BEQ at 0x10, taken, target 0x40, pred_taken=0 -> flush=1 that cycle; next PC=0x40; mispredict_count=1; entry allocated with counter=2. Next fetch of 0x10 -> pred_taken_IF=1, pred_target_IF=0x40, following PC=0x40.
3. Same BEQ predicted taken, resolve not-taken twice -> both mispredict; PC=0x14 after each; counter 2→1→0; third fetch of 0x10 gives pred_taken_IF=0.
4. J at 0x20, target 0x100, on a miss -> flush; counter=3. Three further correct resolves -> no flush, counter stays 3, branch_count increments each time.
5. stall=1 held while a mispredict resolves -> PC loads the corrected PC anyway. With stall=1 and no mispredict -> PC unchanged for 3 cycles.
6. BTB_ENTRIES=8: a non-branch at 0x30 aliasing a taken entry (resolve_pred_taken=1) -> flush; PC=0x34; entry invalidated. Separately, preset mispredict_count to all-ones -> it stays saturated.
